// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_ctrl_pkg;

    // Trap sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } trap_state_e;

    // Synchronous exception cause codes.
    localparam logic [4:0] CAUSE_INSTR_MIS   = 5'd0;
    localparam logic [4:0] CAUSE_INSTR_FAULT = 5'd1;
    localparam logic [4:0] CAUSE_ILLEGAL     = 5'd2;
    localparam logic [4:0] CAUSE_EBREAK      = 5'd3;
    localparam logic [4:0] CAUSE_LOAD_MIS    = 5'd4;
    localparam logic [4:0] CAUSE_STORE_MIS   = 5'd6;
    localparam logic [4:0] CAUSE_ECALL       = 5'd11;

    // Interrupt cause codes.
    localparam logic [4:0] IRQ_MSI = 5'd3;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_MEI = 5'd11;

    // Bit positions inside the exception flag vector.
    localparam int EXC_INSTR_FAULT = 0;
    localparam int EXC_INSTR_MIS   = 1;
    localparam int EXC_ILLEGAL     = 2;
    localparam int EXC_EBREAK      = 3;
    localparam int EXC_ECALL       = 4;
    localparam int EXC_LOAD_MIS    = 5;
    localparam int EXC_STORE_MIS   = 6;

    // mstatus field positions.
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // mtvec mode encodings; anything other than vectored behaves as direct.
    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // mstatus on trap entry: stash MIE in MPIE, disable MIE, MPP = machine.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // mstatus on mret: restore MIE from MPIE, set MPIE, MPP stays machine.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/trap_prio.sv
// Combinational trap arbiter: picks the winning interrupt or exception.
module trap_prio
    import trap_ctrl_pkg::*;
(
    input  logic [6:0] exc_vect,
    input  logic [2:0] pend,       // {mei, mti, msi}
    input  logic [2:0] irq_en,     // {meie, mtie, msie}
    input  logic       global_ie,
    output logic       take,
    output logic       interrupt,
    output logic [4:0] code
);

    logic [2:0] irq_act;

    assign irq_act = pend & irq_en;

    // Interrupts beat exceptions; within each group fixed priority order.
    always_comb begin
        take      = 1'b1;
        interrupt = 1'b0;
        code      = 5'd0;
        if (global_ie && (irq_act != 3'b000)) begin
            interrupt = 1'b1;
            if (irq_act[2])      code = IRQ_MEI;
            else if (irq_act[0]) code = IRQ_MSI;
            else                 code = IRQ_MTI;
        end else if (exc_vect[EXC_INSTR_FAULT]) code = CAUSE_INSTR_FAULT;
        else if (exc_vect[EXC_INSTR_MIS])       code = CAUSE_INSTR_MIS;
        else if (exc_vect[EXC_ILLEGAL])         code = CAUSE_ILLEGAL;
        else if (exc_vect[EXC_EBREAK])          code = CAUSE_EBREAK;
        else if (exc_vect[EXC_ECALL])           code = CAUSE_ECALL;
        else if (exc_vect[EXC_LOAD_MIS])        code = CAUSE_LOAD_MIS;
        else if (exc_vect[EXC_STORE_MIS])       code = CAUSE_STORE_MIS;
        else                                    take = 1'b0;
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates traps/mret at the memory stage,
// produces the CSR write set, and redirects fetch.
// Redirect handshake: REDIRECT_VALID_SM is held with a stable REDIRECT_PC_SM
// until REDIRECT_READY_SI is sampled high in REDIRECT; a transfer happens on a
// clock edge where both are high in REDIRECT. Ready seen in COMMIT is ignored.
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        INSTR_VALID_SM,
    input  logic [31:0] PC_SM,
    input  logic [31:0] INSTR_SM,
    input  logic [31:0] ADR_SM,
    input  logic [6:0]  EXC_VECT_SM,
    input  logic        MRET_SM,
    input  logic        MEIP_I,
    input  logic        MTIP_I,
    input  logic        MSIP_I,
    input  logic [31:0] MSTATUS_RC,
    input  logic [31:0] MTVEC_VALUE_RC,
    input  logic [31:0] MIE_VALUE_RC,
    input  logic [31:0] MEPC_SC,
    input  logic [31:0] MCAUSE_SC,
    output logic        EXCEPTION_SM,
    output logic [31:0] MSTATUS_WDATA_SM,
    output logic [31:0] MIP_WDATA_SM,
    output logic [31:0] MEPC_WDATA_SM,
    output logic [31:0] MCAUSE_WDATA_SM,
    output logic [31:0] MTVAL_WDATA_SM,
    output logic        FLUSH_SM,
    output logic        REDIRECT_VALID_SM,
    output logic [31:0] REDIRECT_PC_SM,
    input  logic        REDIRECT_READY_SI,
    output logic [31:0] TRAP_COUNT_SC,
    output logic [1:0]  state_dbg
);

    trap_state_e state_q, state_d;
    logic [2:0]  pend_q;
    logic [31:0] mstatus_q, mepc_q, mcause_q, mtval_q, redirect_pc_q, count_q;
    logic        take, interrupt;
    logic [4:0]  code;
    logic        evt, trap_go, mret_go;
    logic [31:0] trap_base, trap_target, trap_mtval;

    trap_prio u_prio (
        .exc_vect  (EXC_VECT_SM),
        .pend      (pend_q),
        .irq_en    ({MIE_VALUE_RC[11], MIE_VALUE_RC[7], MIE_VALUE_RC[3]}),
        .global_ie (MSTATUS_RC[MSTATUS_MIE]),
        .take      (take),
        .interrupt (interrupt),
        .code      (code)
    );

    assign evt     = (state_q == ST_IDLE) && INSTR_VALID_SM;
    assign trap_go = evt && take;
    assign mret_go = evt && !take && MRET_SM;

    assign trap_base   = {MTVEC_VALUE_RC[31:2], 2'b00};
    assign trap_target = (interrupt && (MTVEC_VALUE_RC[1:0] == MTVEC_VECTORED))
                         ? trap_base + {25'd0, code, 2'b00} : trap_base;

    // mtval carries the encoding for illegal, the address for faults/misaligned.
    always_comb begin
        trap_mtval = 32'd0;
        if (!interrupt) begin
            case (code)
                CAUSE_ILLEGAL:     trap_mtval = INSTR_SM;
                CAUSE_INSTR_FAULT,
                CAUSE_INSTR_MIS,
                CAUSE_LOAD_MIS,
                CAUSE_STORE_MIS:   trap_mtval = ADR_SM;
                default:           trap_mtval = 32'd0;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_d           = state_q;
        EXCEPTION_SM      = 1'b0;
        FLUSH_SM          = 1'b0;
        REDIRECT_VALID_SM = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trap_go || mret_go) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                EXCEPTION_SM      = 1'b1;
                FLUSH_SM          = 1'b1;
                REDIRECT_VALID_SM = 1'b1;
                state_d           = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                FLUSH_SM          = 1'b1;
                REDIRECT_VALID_SM = 1'b1;
                if (REDIRECT_READY_SI) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Interrupt lines sampled once into pending bits {mei, mti, msi}.
    always_ff @(posedge clk) begin
        if (!reset_n) pend_q <= 3'b000;
        else          pend_q <= {MEIP_I, MTIP_I, MSIP_I};
    end

    // CSR write data, redirect target and trap counter captured on the event cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mstatus_q     <= 32'd0;
            mepc_q        <= 32'd0;
            mcause_q      <= 32'd0;
            mtval_q       <= 32'd0;
            redirect_pc_q <= 32'd0;
            count_q       <= 32'd0;
        end else if (trap_go) begin
            mstatus_q     <= mstatus_on_trap(MSTATUS_RC);
            mepc_q        <= {PC_SM[31:2], 2'b00};
            mcause_q      <= {interrupt, 26'd0, code};
            mtval_q       <= trap_mtval;
            redirect_pc_q <= trap_target;
            if (count_q != 32'hFFFF_FFFF) count_q <= count_q + 32'd1;
        end else if (mret_go) begin
            mstatus_q     <= mstatus_on_mret(MSTATUS_RC);
            mepc_q        <= MEPC_SC;
            mcause_q      <= MCAUSE_SC;
            mtval_q       <= 32'd0;
            redirect_pc_q <= MEPC_SC;
        end
    end

    assign MIP_WDATA_SM     = {20'd0, pend_q[2], 3'd0, pend_q[1], 3'd0, pend_q[0], 3'd0};
    assign MSTATUS_WDATA_SM = mstatus_q;
    assign MEPC_WDATA_SM    = mepc_q;
    assign MCAUSE_WDATA_SM  = mcause_q;
    assign MTVAL_WDATA_SM   = mtval_q;
    assign REDIRECT_PC_SM   = redirect_pc_q;
    assign TRAP_COUNT_SC    = count_q;
    assign state_dbg        = state_q;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, synchronous, active-low.

REQ-002 Pipeline inputs SHALL be:
- INSTR_VALID_SM  in  1  memory-stage instruction valid.
- PC_SM  in  32  its PC.
- INSTR_SM  in  32  its encoding.
- ADR_SM  in  32  its fault address.
- EXC_VECT_SM  in  7  flags {store_mis, load_mis, ecall, ebreak, illegal, instr_mis, instr_fault} [6:0].
- MRET_SM  in  1  mret executing.

REQ-003 Interrupt inputs SHALL be:
- MEIP_I  in  1  external interrupt level.
- MTIP_I  in  1  timer interrupt level.
- MSIP_I  in  1  software interrupt level.

REQ-004 CSR inputs SHALL be MSTATUS_RC, MTVEC_VALUE_RC, MIE_VALUE_RC, MEPC_SC, MCAUSE_SC, each in, 32 bits, current CSR values.

REQ-005 CSR write outputs SHALL be:
- EXCEPTION_SM  out  1  one-cycle CSR trap-write strobe.
- MSTATUS_WDATA_SM, MIP_WDATA_SM, MEPC_WDATA_SM, MCAUSE_WDATA_SM, MTVAL_WDATA_SM  out  32 each.

REQ-006 Fetch-side ports SHALL be:
- FLUSH_SM  out  1  kill all younger stages.
- REDIRECT_VALID_SM  out  1  new PC offered.
- REDIRECT_PC_SM  out  32  target.
- REDIRECT_READY_SI  in  1  fetch accepts.
- TRAP_COUNT_SC  out  32  traps taken.

Function
REQ-007 IRQ inputs SHALL be registered once into pending bits; MIP_WDATA_SM SHALL equal pending bits at 11/7/3, all other bits 0, every cycle.
REQ-008 An interrupt SHALL be eligible when MSTATUS_RC[3]=1 and (pending & MIE_VALUE_RC) is nonzero; priority SHALL be MEI(11) > MSI(3) > MTI(7).
REQ-009 Synchronous cause priority SHALL be instr_fault(1) > instr_mis(0) > illegal(2) > ebreak(3) > ecall(11) > load_mis(4) > store_mis(6).
REQ-010 Events SHALL be evaluated only when INSTR_VALID_SM=1 in state IDLE; an eligible interrupt SHALL win over any synchronous exception and over MRET_SM.
REQ-011 FSM states SHALL be IDLE, COMMIT, REDIRECT.
- IDLE->COMMIT on a trap or mret.
- COMMIT->REDIRECT unconditionally after 1 cycle.
- REDIRECT->IDLE in the cycle REDIRECT_READY_SI=1.
REQ-012 In COMMIT, EXCEPTION_SM SHALL be 1 for exactly that cycle (event cycle N -> strobe N+1); all WDATA values SHALL be registered from cycle N.
REQ-013 Trap WDATA SHALL be as follows.
- MEPC = PC_SM with [1:0] forced 0.
- MCAUSE = {interrupt, 26'b0, code[4:0]}.
- MTVAL = INSTR_SM for illegal, ADR_SM for fault/misaligned, else 0.
- MSTATUS = MSTATUS_RC with MPIE[7] <= MIE[3], MIE[3] <= 0, MPP[12:11] <= 2'b11.
REQ-014 mret WDATA SHALL be as follows.
- MSTATUS: MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.
- MEPC/MCAUSE: current MEPC_SC/MCAUSE_SC echoed.
- MTVAL: current value unknown, so 0 SHALL be written; mtval is documented as clobbered by mret.
REQ-015 The trap target SHALL be {MTVEC_VALUE_RC[31:2], 2'b00}, plus 4*code when MTVEC[1:0]=01 and the trap is an interrupt; modes 10/11 SHALL act as direct. The mret target SHALL be MEPC_SC.
REQ-016 FLUSH_SM SHALL be 1 in COMMIT and REDIRECT.
REQ-017 REDIRECT_VALID_SM SHALL be 1 in COMMIT and REDIRECT.
REQ-018 REDIRECT_PC_SM SHALL stay stable until accepted.
REQ-019 Acceptance in COMMIT SHALL NOT shorten the sequence; REDIRECT is always entered.
REQ-020 Inputs arriving in COMMIT/REDIRECT SHALL be ignored, since the pipeline is flushed.
REQ-021 TRAP_COUNT_SC SHALL increment by 1 per trap (not mret) at COMMIT and saturate at 32'hFFFFFFFF.

Reset
REQ-022 When reset_n=0 at a clock edge, all of the following SHALL be 0:
- state (IDLE), pending bits, counter.
- EXCEPTION_SM, FLUSH_SM, REDIRECT_VALID_SM, REDIRECT_PC_SM.
- all WDATA registers.
REQ-023 Reset in COMMIT/REDIRECT SHALL abandon the trap with no strobe.

Structure
REQ-024 A shared package SHALL hold:
- the FSM state enum.
- the cause-code constants (0,1,2,3,4,6,11, IRQ 3/7/11).
- the mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
- the mtvec mode constants.
REQ-025 One combinational sub-module, trap_prio, SHALL produce {take, interrupt, code[4:0]} from the flags, pending bits and enables.

Verification
REQ-026 The bench SHALL cover these directed scenarios.
- Illegal instr, PC=0x100, INSTR=0xFFFFFFFF, MTVEC=0x800, MSTATUS=0x8 -> next cycle: EXCEPTION_SM=1, MEPC=0x100, MCAUSE=2, MTVAL=0xFFFFFFFF, MSTATUS=0x1880; REDIRECT_PC=0x800.
- MTIP=1, MIE=0x80, MSTATUS=0x8, MTVEC=0x801, ecall also flagged -> MCAUSE=0x80000007, target 0x81C, ecall dropped.
- mret with MSTATUS=0x1880, MEPC=0x104 -> MSTATUS_WDATA=0x1888, REDIRECT_PC=0x104, TRAP_COUNT unchanged.
- REDIRECT_READY held 0 for 5 cycles -> FLUSH/REDIRECT_VALID stay 1 with stable PC; READY=1 -> IDLE next cycle.
- MEIP+MTIP pending, MIE=0x880, MSTATUS.MIE=0 -> no trap; set MSTATUS.MIE=1 -> MCAUSE=0x8000000B.
- reset_n=0 during REDIRECT -> all outputs 0 next edge; counter preset to 0xFFFFFFFF saturates on another trap.
